mult_product_accum: RTL
=======================

// Module: mult_product_accum
// PURPOSE
// Downstream consumer of the 4x4 sequential multiplier (mult_4x4). Detects
// each completed multiply from the multiplier's asynchronous Finish flag,
// captures the 8-bit product, and accumulates NUM_TERMS products into one sum.
// Presents the sum on a valid/ready handshake, with a one-entry skid register
// so that a product arriving while the sum is held is not lost.
// PARAMETERS
// NUM_TERMS  4   products per sum (>=1)
// SUM_W      12  sum width (>=8+clog2(NUM_TERMS) for no overflow at defaults)
// CNT_W      3   term counter width (must hold NUM_TERMS)
// PORTS
// clk        in   1      system clock, rising edge
// reset_n    in   1      synchronous, active-low reset
// product    in   8      multiplier result O; stable from Finish fall to next Finish rise
// finish     in   1      multiplier Finish flag, asynchronous to clk
// clear      in   1      sync abort: drop partial sum, skid entry and sticky flags
// sum        out  SUM_W  accumulated sum; meaningful only while sum_valid=1
// sum_valid  out  1      sum ready for consumer
// sum_ready  in   1      consumer accepts sum when sum_valid&sum_ready at clk edge
// term_cnt   out  CNT_W  products folded into the current partial sum
// overflow   out  1      sticky: a carry out of SUM_W occurred
// drop_err   out  1      sticky: a product arrived with skid register full
// BEHAVIOUR
// - Reset (reset_n=0 at clk edge): sum=0, sum_valid=0, term_cnt=0,
//   overflow=0, drop_err=0, skid empty, sync flops=0, FSM=ACCUM.
// - Sync: finish passes through 2 flops (f1, f2) plus a history flop f3.
//   Capture event cap = f3 & ~f2, i.e. Finish FALLING edge, because O
//   updates on the same multiplier edge that drops Finish. product is
//   sampled directly in the cap cycle: 3 clk latency, well within O stability.
// - One cap per Finish pulse, however long the pulse lasts.
// - FSM ACCUM: on cap, sum<=sum+product (zero-extended, mod 2^SUM_W; set
//   overflow on carry out) and term_cnt++. When term_cnt reaches NUM_TERMS,
//   go to HOLD with sum_valid=1 the next cycle.
// - FSM HOLD: sum and term_cnt frozen. On cap: if skid empty, store the product
//   in skid. If skid full, discard the product and set drop_err.
// - Handshake in HOLD (sum_valid&sum_ready): sum_valid<=0 and go to ACCUM.
//   If skid full: sum<=skid, term_cnt<=1, skid emptied.
//   Else: sum<=0, term_cnt<=0.
//   If cap occurs in the same cycle as the handshake, it is treated as
//   arriving after the skid reload: it is added to the new sum.
// - NUM_TERMS=1: every cap goes straight to HOLD.
// - sum_ready while sum_valid=0 is ignored.
// - clear (priority below reset, above all else): sum=0, term_cnt=0,
//   sum_valid=0, skid empty, overflow=0, drop_err=0, FSM=ACCUM.
//   Sync flops are NOT cleared, so a Finish pulse in flight still yields
//   at most one cap after clear deasserts.
// - Reset or clear mid-accumulation discards the partial sum; no output is
//   produced for it.
// - sum_valid must not deassert without a handshake, except on reset/clear.
// TESTING
// 1 Reset, then 4 Finish pulses with products 0x0F,0x10,0x01,0xE1 ->
//   sum_valid=1 and sum=0x101 three clk after the 4th Finish fall.
//   term_cnt=4, overflow=0.
// 2 Finish held high for 20 clk, product=0x09 -> exactly one cap;
//   term_cnt goes 0->1 only after the fall.
// 3 HOLD with sum_ready=0: deliver 0x22, then 0x33 -> skid=0x22 and
//   drop_err=1. Then assert sum_ready -> sum=0x22, term_cnt=1, sum_valid=0.
// 4 SUM_W=8, four products of 0xFF -> overflow=1, sum=0xFC.
// 5 Handshake in the same cycle as a cap of 0x05, skid empty ->
//   ACCUM with sum=0x05, term_cnt=1.
// 6 clear after 2 terms -> sum=0, term_cnt=0; the next 4 products form a
//   clean sum. reset_n=0 in HOLD -> all outputs at their reset values.

Source files
------------

// File: rtl/mult_product_accum.sv
// Accumulates products from the 4x4 sequential multiplier into NUM_TERMS-term
// sums and presents each sum on a valid/ready handshake, with a one-entry skid.
module mult_product_accum #(
    parameter int NUM_TERMS = 4,
    parameter int SUM_W     = 12,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       product,
    input  logic             finish,
    input  logic             clear,
    output logic [SUM_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [CNT_W-1:0] term_cnt,
    output logic             overflow,
    output logic             drop_err
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TERMS = CNT_W'(NUM_TERMS);

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             drop_q, drop_d;
    logic [7:0]       skid_q, skid_d;
    logic             skid_full_q, skid_full_d;
    logic             f1_q, f1_d;
    logic             f2_q, f2_d;
    logic             f3_q, f3_d;

    logic             cap;
    logic             accum_en;
    logic [SUM_W-1:0] base_sum;
    logic [CNT_W-1:0] base_cnt;
    logic [SUM_W:0]   add;

    // Two-flop synchronizer for Finish plus history flop for fall detect
    always_comb begin
        f1_d = finish;
        f2_d = f1_q;
        f3_d = f2_q;
    end

    assign cap = f3_q & ~f2_q;

    // Next-state logic: accumulate, hold with skid, handshake reload, clear
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        base_sum    = sum_q;
        base_cnt    = cnt_q;
        accum_en    = 1'b0;

        unique case (state_q)
            ACCUM: begin
                accum_en = cap;
            end
            HOLD: begin
                if (sum_ready) begin
                    state_d = ACCUM;
                    if (skid_full_q) begin
                        base_sum    = SUM_W'(skid_q);
                        base_cnt    = CNT_W'(1);
                        skid_full_d = 1'b0;
                    end else begin
                        base_sum = '0;
                        base_cnt = '0;
                    end
                    sum_d    = base_sum;
                    cnt_d    = base_cnt;
                    accum_en = cap;
                end else if (cap) begin
                    if (!skid_full_q) begin
                        skid_d      = product;
                        skid_full_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase

        add = {1'b0, base_sum} + {{(SUM_W + 1 - 8){1'b0}}, product};

        if (accum_en) begin
            sum_d = add[SUM_W-1:0];
            cnt_d = base_cnt + CNT_W'(1);
            if (add[SUM_W]) begin
                ovf_d = 1'b1;
            end
            if (cnt_d == TERMS) begin
                state_d = HOLD;
            end
        end

        if (clear) begin
            state_d     = ACCUM;
            sum_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            drop_d      = 1'b0;
            skid_full_d = 1'b0;
        end
    end

    // Synchronizer registers; cleared only by reset so clear cannot double-cap
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f1_q <= 1'b0;
            f2_q <= 1'b0;
            f3_q <= 1'b0;
        end else begin
            f1_q <= f1_d;
            f2_q <= f2_d;
            f3_q <= f3_d;
        end
    end

    // Accumulator, FSM, skid and sticky flag registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = (state_q == HOLD);
    assign term_cnt  = cnt_q;
    assign overflow  = ovf_q;
    assign drop_err  = drop_q;

endmodule
